// File: rtl/mef_rega.sv
// Irrigation sequencing FSM: timed sprinkler/drip runs, mandatory pause, latched fault.
// Optional request-stability filter in idle is enabled by defining REGA_FILTRO_EN.
module mef_rega #(
    parameter int unsigned T_ASP    = 10,
    parameter int unsigned T_GOT    = 20,
    parameter int unsigned T_PAUSA  = 5,
    parameter int unsigned T_FILTRO = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] rega,
    input  logic       erro,
    input  logic       tick,
    input  logic       rec,
    output logic       valv_asp,
    output logic       valv_got,
    output logic       alarme,
    output logic       fim,
    output logic [2:0] estado
);

    localparam int unsigned T_MAX_AG = (T_ASP > T_GOT) ? T_ASP : T_GOT;
    localparam int unsigned T_MAX    = (T_MAX_AG > T_PAUSA) ? T_MAX_AG : T_PAUSA;
    localparam int unsigned CNT_W    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [2:0] {
        OCIOSO = 3'b000,
        ASP    = 3'b001,
        GOT    = 3'b010,
        PAUSA  = 3'b011,
        FALHA  = 3'b100
    } estado_t;

    // Elaboration-time guard on the run/filter lengths
    if (T_ASP < 1 || T_GOT < 1 || T_PAUSA < 1 || T_FILTRO < 1) begin : g_param_err
        $error("mef_rega: all timing parameters must be >= 1");
    end

    estado_t          state;
    logic [CNT_W-1:0] cnt;
    logic             aceita;

`ifdef REGA_FILTRO_EN
    localparam int unsigned FILT_W = $clog2(T_FILTRO + 1);

    logic [FILT_W-1:0] filt_cnt;
    logic [1:0]        filt_val;
    logic [FILT_W-1:0] filt_seen;

    // Consecutive edges the current request has been stable, including this one
    assign filt_seen = (rega == filt_val && filt_cnt != '0) ? filt_cnt + FILT_W'(1) : FILT_W'(1);
    assign aceita    = (filt_seen >= FILT_W'(T_FILTRO));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_cnt <= '0;
            filt_val <= 2'b00;
        end else if (state == OCIOSO && !erro && (rega == 2'b10 || rega == 2'b01) && !aceita) begin
            filt_cnt <= filt_seen;
            filt_val <= rega;
        end else begin
            filt_cnt <= '0;
            filt_val <= 2'b00;
        end
    end
`else
    assign aceita = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= OCIOSO;
            cnt   <= '0;
            fim   <= 1'b0;
        end else begin
            fim <= 1'b0;
            if (erro) begin
                state <= FALHA;
                cnt   <= '0;
            end else begin
                case (state)
                    OCIOSO: begin
                        cnt <= '0;
                        if (rega == 2'b11) begin
                            state <= FALHA;
                        end else if (rega == 2'b10 && aceita) begin
                            state <= ASP;
                        end else if (rega == 2'b01 && aceita) begin
                            state <= GOT;
                        end
                    end
                    ASP: begin
                        if (tick && cnt == CNT_W'(T_ASP - 1)) begin
                            state <= PAUSA;
                            cnt   <= '0;
                            fim   <= 1'b1;
                        end else if (rega != 2'b10) begin
                            state <= PAUSA;
                            cnt   <= '0;
                        end else if (tick) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    GOT: begin
                        if (tick && cnt == CNT_W'(T_GOT - 1)) begin
                            state <= PAUSA;
                            cnt   <= '0;
                            fim   <= 1'b1;
                        end else if (rega != 2'b01) begin
                            state <= PAUSA;
                            cnt   <= '0;
                        end else if (tick) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    PAUSA: begin
                        if (tick && cnt == CNT_W'(T_PAUSA - 1)) begin
                            state <= OCIOSO;
                            cnt   <= '0;
                        end else if (tick) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    FALHA: begin
                        cnt <= '0;
                        if (rec) begin
                            state <= OCIOSO;
                        end
                    end
                    default: begin
                        state <= FALHA;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Valve/alarm decode straight from the state register; ASP and GOT are exclusive codes
    assign valv_asp = (state == ASP);
    assign valv_got = (state == GOT);
    assign alarme   = (state == FALHA);
    assign estado   = state;

endmodule

// File: tb/tb_mef_rega.sv
// Directed self-checking bench for mef_rega (T_ASP=3, T_GOT=6, T_PAUSA=5, T_FILTRO=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_mef_rega;

    localparam int unsigned T_ASP    = 3;
    localparam int unsigned T_GOT    = 6;
    localparam int unsigned T_PAUSA  = 5;
    localparam int unsigned T_FILTRO = 4;
`ifdef REGA_FILTRO_EN
    localparam int unsigned LAT = T_FILTRO;
`else
    localparam int unsigned LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] rega;
    logic       erro;
    logic       tick;
    logic       rec;
    logic       valv_asp;
    logic       valv_got;
    logic       alarme;
    logic       fim;
    logic [2:0] estado;

    int checks = 0;
    int errors = 0;

    mef_rega #(
        .T_ASP(T_ASP), .T_GOT(T_GOT), .T_PAUSA(T_PAUSA), .T_FILTRO(T_FILTRO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rega(rega), .erro(erro), .tick(tick), .rec(rec),
        .valv_asp(valv_asp), .valv_got(valv_got), .alarme(alarme), .fim(fim), .estado(estado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic tk();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic start_req(input logic [1:0] v);
        rega = v;
        cyc(int'(LAT));
    endtask

    task automatic outs(input string tag, input int e_est, input int e_asp, input int e_got,
                        input int e_alm, input int e_fim);
        chk({tag, ".estado"}, int'(estado), e_est);
        chk({tag, ".valv_asp"}, int'(valv_asp), e_asp);
        chk({tag, ".valv_got"}, int'(valv_got), e_got);
        chk({tag, ".alarme"}, int'(alarme), e_alm);
        chk({tag, ".fim"}, int'(fim), e_fim);
    endtask

    initial begin
        rst_n = 1'b0; rega = 2'b00; erro = 1'b0; tick = 1'b0; rec = 1'b0;
        @(negedge clk);
        step();
        outs("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        outs("idle", 0, 0, 0, 0, 0);

        // Sprinkler run: tick every 4 cycles, 3 ticks, then pause of 5 ticks
        start_req(2'b10);
        outs("asp_entry", 1, 1, 0, 0, 0);
        cyc(3); tk();
        cyc(3); tk();
        outs("asp_tick2", 1, 1, 0, 0, 0);
        cyc(3); tk();
        outs("asp_done", 3, 0, 0, 0, 1);
        rega = 2'b00;
        step();
        chk("fim_one_cycle", int'(fim), 0);
        for (int i = 0; i < 4; i++) tk();
        chk("pausa_tick4", int'(estado), 3);
        tk();
        chk("pausa_done", int'(estado), 0);

        // Drip run aborted by a switch to sprinkler after one tick
        start_req(2'b01);
        outs("got_entry", 2, 0, 1, 0, 0);
        tk();
        rega = 2'b10;
        step();
        outs("got_abort", 3, 0, 0, 0, 0);
        cyc(2);
        chk("abort_no_asp", int'(estado), 3);
        for (int i = 0; i < 5; i++) tk();
        chk("abort_pausa_done", int'(estado), 0);
        start_req(2'b10);
        chk("asp_after_pause", int'(estado), 1);

        // erro on the same edge as the final tick wins
        tk(); tk();
        erro = 1'b1; tick = 1'b1;
        step();
        tick = 1'b0;
        outs("erro_vs_timeout", 4, 0, 0, 1, 0);
        rec = 1'b1;
        step();
        chk("rec_with_erro", int'(estado), 4);
        erro = 1'b0; rega = 2'b00;
        step();
        outs("rec_clears", 0, 0, 0, 0, 0);
        rec = 1'b0;

        // Illegal request in idle
        rega = 2'b11;
        step();
        outs("illegal_req", 4, 0, 0, 1, 0);
        rega = 2'b00; rec = 1'b1;
        step();
        rec = 1'b0;
        chk("illegal_cleared", int'(estado), 0);

`ifdef REGA_FILTRO_EN
        // Request held too briefly is dropped; held T_FILTRO edges is accepted on the last
        rega = 2'b10;
        cyc(3);
        chk("filt_3_edges", int'(estado), 0);
        rega = 2'b00;
        step();
        chk("filt_dropped", int'(estado), 0);
        rega = 2'b10;
        cyc(3);
        chk("filt_edge3", int'(estado), 0);
        step();
        chk("filt_edge4", int'(estado), 1);
        rega = 2'b00;
        step();
        for (int i = 0; i < 5; i++) tk();
        chk("filt_back_idle", int'(estado), 0);
`endif

        // Reset in the middle of a drip run at tick 5, then a full-length run
        start_req(2'b01);
        for (int i = 0; i < 4; i++) tk();
        chk("got_tick4", int'(valv_got), 1);
        rst_n = 1'b0; tick = 1'b1;
        step();
        tick = 1'b0;
        outs("reset_mid_got", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        start_req(2'b01);
        chk("got_restart", int'(estado), 2);
        for (int i = 0; i < 5; i++) tk();
        chk("got_full_tick5", int'(valv_got), 1);
        tk();
        outs("got_full_done", 3, 0, 0, 0, 1);

        // Continuous tick counts once per cycle through the pause
        rega = 2'b00; tick = 1'b1;
        cyc(4);
        chk("cont_tick4", int'(estado), 3);
        step();
        tick = 1'b0;
        chk("cont_tick5", int'(estado), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
